// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode codes, RV32I major opcodes and the decoded bundle shared with execute.
package alu_pkg;

  localparam logic [4:0] ALU_EQ  = 5'b00000;
  localparam logic [4:0] ALU_GT  = 5'b00001;
  localparam logic [4:0] ALU_GTU = 5'b00010;
  localparam logic [4:0] ALU_LT  = 5'b00011;
  localparam logic [4:0] ALU_LTU = 5'b00100;
  localparam logic [4:0] ALU_LE  = 5'b00101;
  localparam logic [4:0] ALU_NE  = 5'b00110;
  localparam logic [4:0] ALU_SRA = 5'b10111;
  localparam logic [4:0] ALU_SLL = 5'b11000;
  localparam logic [4:0] ALU_SRL = 5'b11001;
  localparam logic [4:0] ALU_ADD = 5'b11010;
  localparam logic [4:0] ALU_SUB = 5'b11011;
  localparam logic [4:0] ALU_XOR = 5'b11100;
  localparam logic [4:0] ALU_AND = 5'b11101;
  localparam logic [4:0] ALU_OR  = 5'b10000;

  localparam logic [1:0] ASEL_RS1  = 2'b00;
  localparam logic [1:0] ASEL_PC   = 2'b01;
  localparam logic [1:0] ASEL_ZERO = 2'b10;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [4:0]  op_alu;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  mem_f3;
    logic        is_branch;
    logic        is_jump;
    logic        br_invert;
    logic [31:0] pc;
    logic        illegal;
  } dec_bundle_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} stage_state_t;

  function automatic dec_bundle_t reset_bundle();
    dec_bundle_t b;
    b = '0;
    b.op_alu = ALU_ADD;
    return b;
  endfunction

  // alt selects SUB/SRA; callers only raise it where the encoding allows
  function automatic logic [4:0] alu_func(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_LT;
      3'b011:  return ALU_LTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_alu_decode_comb.sv
// rtl/rv32i_alu_decode_comb.sv - pure combinational RV32I word -> decoded bundle.
// ALU_DECODE_ILLEGAL_EN: flag unrecognised encodings via illegal; otherwise they become ADDI x0,x0,0.
module rv32i_alu_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic [31:0]  pc,
  output dec_bundle_t  dec
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal;
  dec_bundle_t d;

  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    d        = '0;
    legal    = 1'b1;
    d.op_alu = ALU_ADD;
    d.pc     = pc;
    d.mem_f3 = f3;
    case (opcode)
      OPC_OP: begin
        d.rs1 = rs1_f; d.rs2 = rs2_f; d.rd = rd_f; d.reg_we = 1'b1;
        d.op_alu = alu_func(f3, f7[5]);
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
      end
      OPC_OP_IMM: begin
        d.rs1 = rs1_f; d.rd = rd_f; d.reg_we = 1'b1; d.b_sel = 1'b1;
        d.op_alu = alu_func(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001 || f3 == 3'b101) begin
          d.imm = {27'b0, instr[24:20]};
          legal = (f7 == 7'h00) || (f3 == 3'b101 && f7 == 7'h20);
        end else begin
          d.imm = imm_i;
        end
      end
      OPC_LOAD: begin
        d.rs1 = rs1_f; d.rd = rd_f; d.reg_we = 1'b1; d.b_sel = 1'b1;
        d.imm = imm_i; d.mem_rd = 1'b1;
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OPC_STORE: begin
        d.rs1 = rs1_f; d.rs2 = rs2_f; d.b_sel = 1'b1;
        d.imm = imm_s; d.mem_wr = 1'b1;
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      end
      OPC_BRANCH: begin
        d.rs1 = rs1_f; d.rs2 = rs2_f; d.imm = imm_b; d.is_branch = 1'b1;
        d.br_invert = f3[0] && f3[2];
        case (f3)
          3'b000:          d.op_alu = ALU_EQ;
          3'b001:          d.op_alu = ALU_NE;
          3'b100, 3'b101:  d.op_alu = ALU_LT;
          default:         d.op_alu = ALU_LTU;
        endcase
        legal = (f3[2:1] != 2'b01);
      end
      OPC_JALR: begin
        d.rs1 = rs1_f; d.rd = rd_f; d.reg_we = 1'b1; d.b_sel = 1'b1;
        d.imm = imm_i; d.is_jump = 1'b1;
        legal = (f3 == 3'b000);
      end
      OPC_JAL: begin
        d.rd = rd_f; d.reg_we = 1'b1; d.b_sel = 1'b1; d.a_sel = ASEL_PC;
        d.imm = imm_j; d.is_jump = 1'b1;
      end
      OPC_LUI: begin
        d.rd = rd_f; d.reg_we = 1'b1; d.b_sel = 1'b1; d.a_sel = ASEL_ZERO; d.imm = imm_u;
      end
      OPC_AUIPC: begin
        d.rd = rd_f; d.reg_we = 1'b1; d.b_sel = 1'b1; d.a_sel = ASEL_PC; d.imm = imm_u;
      end
      default: legal = 1'b0;
    endcase
    if (d.rd == 5'd0) d.reg_we = 1'b0;
    if (!legal) begin
      d        = '0;
      d.op_alu = ALU_ADD;
      d.b_sel  = 1'b1;
      d.pc     = pc;
`ifdef ALU_DECODE_ILLEGAL_EN
      d.illegal = 1'b1;
`else
      d.illegal = 1'b0;
`endif
    end
  end

  assign dec = d;

endmodule

// File: rtl/rv32i_alu_decode_stage.sv
// rtl/rv32i_alu_decode_stage.sv - elastic decode stage: main register plus skid entry, 1-cycle latency.
// Illegal-encoding flagging is enabled by ALU_DECODE_ILLEGAL_EN (see rv32i_alu_decode_comb).
module rv32i_alu_decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      op_alu,
  output logic [1:0]      a_sel,
  output logic            b_sel,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_we,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [2:0]      mem_f3,
  output logic            is_branch,
  output logic            is_jump,
  output logic            br_invert,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  stage_state_t state, state_next;
  dec_bundle_t  dec, main_q, skid_q;
  logic         accept, drain, load_main_in, load_main_skid, load_skid;

  rv32i_alu_decode_comb u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_ONE;
      ST_ONE: begin
        if (accept && !drain)      state_next = ST_TWO;
        else if (drain && !accept) state_next = ST_EMPTY;
      end
      ST_TWO:   if (drain) state_next = ST_ONE;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    in_ready       = (state != ST_TWO);
    out_valid      = (state != ST_EMPTY);
    accept         = in_valid && in_ready;
    drain          = out_valid && out_ready;
    load_main_in   = accept && ((state == ST_EMPTY) || drain);
    load_skid      = accept && (state == ST_ONE) && !drain;
    load_main_skid = (state == ST_TWO) && drain;
  end

  // skid always holds the younger word, so it refills main before any new input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= reset_bundle();
      skid_q <= reset_bundle();
    end else begin
      if (load_main_skid)    main_q <= skid_q;
      else if (load_main_in) main_q <= dec;
      if (load_skid)         skid_q <= dec;
    end
  end

  assign op_alu    = main_q.op_alu;
  assign a_sel     = main_q.a_sel;
  assign b_sel     = main_q.b_sel;
  assign imm       = main_q.imm;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign rd        = main_q.rd;
  assign reg_we    = main_q.reg_we;
  assign mem_rd    = main_q.mem_rd;
  assign mem_wr    = main_q.mem_wr;
  assign mem_f3    = main_q.mem_f3;
  assign is_branch = main_q.is_branch;
  assign is_jump   = main_q.is_jump;
  assign br_invert = main_q.br_invert;
  assign pc_out    = main_q.pc;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_rv32i_alu_decode_stage.sv
// tb/tb_rv32i_alu_decode_stage.sv - scoreboard bench with a mask/match reference decoder.
// Honours ALU_DECODE_ILLEGAL_EN the same way the design does.
module tb_rv32i_alu_decode_stage;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, imm, pc_out;
  logic [4:0]  op_alu, rs1, rs2, rd;
  logic [1:0]  a_sel;
  logic [2:0]  mem_f3;
  logic        b_sel, reg_we, mem_rd, mem_wr, is_branch, is_jump, br_invert, illegal;

  rv32i_alu_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .op_alu(op_alu), .a_sel(a_sel), .b_sel(b_sel), .imm(imm), .rs1(rs1), .rs2(rs2),
    .rd(rd), .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_f3(mem_f3),
    .is_branch(is_branch), .is_jump(is_jump), .br_invert(br_invert),
    .pc_out(pc_out), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_we, mem_rd, mem_wr;
    logic [2:0]  mem_f3;
    logic        is_branch, is_jump, br_invert;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;

  localparam int F_R = 0, F_I = 1, F_SH = 2, F_L = 3, F_S = 4, F_B = 5,
                 F_JR = 6, F_J = 7, F_LUI = 8, F_AUIPC = 9;
  localparam logic [4:0] ADD = 5'b11010;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [4:0]  op;
    int          fmt;
    bit          inv;
  } ent_t;

  ent_t tab[$];
  exp_t q[$];
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [31:0] m, input logic [31:0] k, input logic [4:0] op,
                              input int fmt, input bit inv);
    ent_t e;
    e.mask = m; e.match = k; e.op = op; e.fmt = fmt; e.inv = inv;
    tab.push_back(e);
  endfunction

  task automatic build_table();
    add(32'hFE00707F, 32'h00000033, 5'b11010, F_R, 0);
    add(32'hFE00707F, 32'h40000033, 5'b11011, F_R, 0);
    add(32'hFE00707F, 32'h00001033, 5'b11000, F_R, 0);
    add(32'hFE00707F, 32'h00002033, 5'b00011, F_R, 0);
    add(32'hFE00707F, 32'h00003033, 5'b00100, F_R, 0);
    add(32'hFE00707F, 32'h00004033, 5'b11100, F_R, 0);
    add(32'hFE00707F, 32'h00005033, 5'b11001, F_R, 0);
    add(32'hFE00707F, 32'h40005033, 5'b10111, F_R, 0);
    add(32'hFE00707F, 32'h00006033, 5'b10000, F_R, 0);
    add(32'hFE00707F, 32'h00007033, 5'b11101, F_R, 0);
    add(32'h0000707F, 32'h00000013, 5'b11010, F_I, 0);
    add(32'h0000707F, 32'h00002013, 5'b00011, F_I, 0);
    add(32'h0000707F, 32'h00003013, 5'b00100, F_I, 0);
    add(32'h0000707F, 32'h00004013, 5'b11100, F_I, 0);
    add(32'h0000707F, 32'h00006013, 5'b10000, F_I, 0);
    add(32'h0000707F, 32'h00007013, 5'b11101, F_I, 0);
    add(32'hFE00707F, 32'h00001013, 5'b11000, F_SH, 0);
    add(32'hFE00707F, 32'h00005013, 5'b11001, F_SH, 0);
    add(32'hFE00707F, 32'h40005013, 5'b10111, F_SH, 0);
    add(32'h0000707F, 32'h00000003, 5'b11010, F_L, 0);
    add(32'h0000707F, 32'h00001003, 5'b11010, F_L, 0);
    add(32'h0000707F, 32'h00002003, 5'b11010, F_L, 0);
    add(32'h0000707F, 32'h00004003, 5'b11010, F_L, 0);
    add(32'h0000707F, 32'h00005003, 5'b11010, F_L, 0);
    add(32'h0000707F, 32'h00000023, 5'b11010, F_S, 0);
    add(32'h0000707F, 32'h00001023, 5'b11010, F_S, 0);
    add(32'h0000707F, 32'h00002023, 5'b11010, F_S, 0);
    add(32'h0000707F, 32'h00000063, 5'b00000, F_B, 0);
    add(32'h0000707F, 32'h00001063, 5'b00110, F_B, 0);
    add(32'h0000707F, 32'h00004063, 5'b00011, F_B, 0);
    add(32'h0000707F, 32'h00005063, 5'b00011, F_B, 1);
    add(32'h0000707F, 32'h00006063, 5'b00100, F_B, 0);
    add(32'h0000707F, 32'h00007063, 5'b00100, F_B, 1);
    add(32'h0000707F, 32'h00000067, 5'b11010, F_JR, 0);
    add(32'h0000007F, 32'h0000006F, 5'b11010, F_J, 0);
    add(32'h0000007F, 32'h00000037, 5'b11010, F_LUI, 0);
    add(32'h0000007F, 32'h00000017, 5'b11010, F_AUIPC, 0);
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int hit = -1, fmt;
    logic [31:0] sgn, rdf;
    for (int i = 0; i < tab.size(); i++)
      if (hit < 0 && (w & tab[i].mask) == tab[i].match) hit = i;
    e = '0;
    e.pc = pc;
    e.op = ADD;
    if (hit < 0) begin
      e.b_sel = 1'b1;
`ifdef ALU_DECODE_ILLEGAL_EN
      e.illegal = 1'b1;
`endif
      return e;
    end
    fmt = tab[hit].fmt;
    e.op = tab[hit].op;
    e.br_invert = tab[hit].inv;
    e.mem_f3 = 3'((w >> 12) & 7);
    sgn = w[31] ? 32'hFFFFFFFF : 32'h0;
    rdf = (w >> 7) & 31;
    if (!(fmt == F_J || fmt == F_LUI || fmt == F_AUIPC)) e.rs1 = 5'((w >> 15) & 31);
    if (fmt == F_R || fmt == F_S || fmt == F_B) e.rs2 = 5'((w >> 20) & 31);
    if (!(fmt == F_S || fmt == F_B)) begin
      e.rd = 5'(rdf);
      e.reg_we = (rdf != 0);
    end
    e.b_sel = !(fmt == F_R || fmt == F_B);
    e.a_sel = (fmt == F_J || fmt == F_AUIPC) ? 2'd1 : (fmt == F_LUI) ? 2'd2 : 2'd0;
    e.mem_rd = (fmt == F_L);
    e.mem_wr = (fmt == F_S);
    e.is_branch = (fmt == F_B);
    e.is_jump = (fmt == F_J || fmt == F_JR);
    case (fmt)
      F_I, F_L, F_JR: e.imm = (sgn << 12) | (w >> 20);
      F_SH:           e.imm = (w >> 20) & 31;
      F_S:            e.imm = (sgn << 12) | (((w >> 25) & 127) << 5) | ((w >> 7) & 31);
      F_B:            e.imm = (sgn << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 63) << 5)
                              | (((w >> 8) & 15) << 1);
      F_J:            e.imm = (sgn << 20) | (w & 32'h000FF000) | (((w >> 20) & 1) << 11)
                              | (((w >> 21) & 32'h3FF) << 1);
      F_LUI, F_AUIPC: e.imm = w & 32'hFFFFF000;
      default:        e.imm = 32'h0;
    endcase
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a = '{op_alu, a_sel, b_sel, imm, rs1, rs2, rd, reg_we, mem_rd, mem_wr, mem_f3,
          is_branch, is_jump, br_invert, pc_out, illegal};
    return a;
  endfunction

  function automatic logic [31:0] gen();
    ent_t e;
    if ($urandom_range(0, 9) < 2) return $urandom;
    e = tab[$urandom_range(0, tab.size() - 1)];
    return e.match | ($urandom & ~e.mask);
  endfunction

  // scoreboard: front entry must be on the outputs whenever out_valid, stalled or not
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 128'(actual()), 128'(0));
        end else begin
          chk("bundle", 128'(actual()), 128'(q[0]));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_instr, in_pc));
    end
  end

  task automatic send_dir(input logic [31:0] w);
    chk("dir_in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b1; in_instr = w; in_pc = $urandom & ~32'h3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("dir_latency", 128'(out_valid), 128'(1));
  endtask

  task automatic drain_cycle();
    @(posedge clk); #1;
  endtask

  logic [31:0] words[3];
  int          n_acc, cyc;
  bit          acc;

  initial begin
    build_table();
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_bundle", 128'(actual()), 128'({5'b11010, 92'h0}));
    rst = 1'b0;
    @(posedge clk); #1;

    send_dir(32'h002081B3);
    chk("add_op", 128'(op_alu), 128'(5'b11010));
    chk("add_asel", 128'(a_sel), 128'(0));
    chk("add_bsel", 128'(b_sel), 128'(0));
    chk("add_rd", 128'(rd), 128'(3));
    chk("add_we", 128'(reg_we), 128'(1));
    drain_cycle();
    send_dir(32'h0020D463);
    chk("bge_op", 128'(op_alu), 128'(5'b00011));
    chk("bge_inv", 128'(br_invert), 128'(1));
    chk("bge_br", 128'(is_branch), 128'(1));
    chk("bge_imm", 128'(imm), 128'(32'h8));
    chk("bge_we", 128'(reg_we), 128'(0));
    drain_cycle();
    send_dir(32'h123452B7);
    chk("lui_op", 128'(op_alu), 128'(5'b11010));
    chk("lui_asel", 128'(a_sel), 128'(2));
    chk("lui_bsel", 128'(b_sel), 128'(1));
    chk("lui_imm", 128'(imm), 128'(32'h12345000));
    drain_cycle();
    send_dir(32'h4030D213);
    chk("srai_op", 128'(op_alu), 128'(5'b10111));
    chk("srai_imm", 128'(imm), 128'(3));
    drain_cycle();
    send_dir(32'hFFFFFFFF);
`ifdef ALU_DECODE_ILLEGAL_EN
    chk("ill_flag", 128'(illegal), 128'(1));
`else
    chk("ill_flag", 128'(illegal), 128'(0));
`endif
    chk("ill_we", 128'(reg_we), 128'(0));
    chk("ill_op", 128'(op_alu), 128'(5'b11010));
    drain_cycle();

    // backpressure: three words offered against a stalled consumer
    words[0] = 32'h002081B3; words[1] = 32'h00100293; words[2] = 32'h0020C3B3;
    out_ready = 1'b0; n_acc = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_instr = words[n_acc]; in_pc = 32'h100 + 32'(4 * n_acc);
      @(negedge clk); if (in_ready) n_acc++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", 128'(n_acc), 128'(2));
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    out_ready = 1'b1; cyc = 0;
    while (n_acc < 3 && cyc < 10) begin
      in_instr = words[n_acc]; in_pc = 32'h100 + 32'(4 * n_acc);
      @(negedge clk); if (in_ready) n_acc++;
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    chk("bp_third_taken", 128'(n_acc), 128'(3));
    repeat (3) drain_cycle();

    // reset while both entries are full
    out_ready = 1'b0; n_acc = 0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_instr = gen(); in_pc = $urandom & ~32'h3;
      @(negedge clk); if (in_ready) n_acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("two_full", 128'(in_ready), 128'(0));
    #2 rst = 1'b1;
    q.delete();
    #1 chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("post_rst_in_ready", 128'(in_ready), 128'(1));
      chk("post_rst_no_replay", 128'(out_valid), 128'(0));
      @(posedge clk); #1;
    end

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 99) < 70);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 99) < 75);
        in_instr = gen();
        in_pc = $urandom & ~32'h3;
      end
    end
    // let any held word be accepted before stopping input
    cyc = 0;
    while (in_valid && cyc < 10) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; cyc++;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("drain_empty", 128'(q.size()), 128'(0));
    chk("drain_out_valid", 128'(out_valid), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
